// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer between the core fetch stage and the memoryController instruction port.
// Define FETCH_PREFETCH_EN for sequential fetch-ahead into a DEPTH-entry queue; otherwise one word per miss.
module instr_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_enable,
  input  logic [31:0] cpu_addr,
  output logic        cpu_valid,
  output logic [31:0] cpu_instr,
  input  logic        flush,
  output logic        mem_enable,
  output logic [24:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_result
);

`ifdef FETCH_PREFETCH_EN
  localparam int QD = DEPTH;
  localparam bit PREFETCH = 1'b1;
`else
  localparam int QD = 1;
  localparam bit PREFETCH = 1'b0;
`endif

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;

  typedef enum logic {
    IDLE,
    REQ
  } mem_state_t;

  mem_state_t  state;
  logic        stream_ok;
  logic        inflight;
  logic        discard;
  logic [31:0] head_addr;
  logic [31:0] fetch_addr;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0] queue [2**PW];

  logic        cpu_req;
  logic        head_match;
  logic        hit;
  logic        pending;
  logic        miss;
  logic        take_miss;
  logic        mem_done;
  logic        push;
  logic        pop;
  logic        issue;
  logic        stream_ok_nx;
  logic [CW-1:0] count_nx;
  logic [31:0] aligned_addr;
  logic [31:0] fetch_addr_base;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
  endfunction

  // The core's enable lags by a cycle, so it is ignored while cpu_valid is high.
  assign cpu_req      = cpu_enable && !cpu_valid;
  assign aligned_addr = {cpu_addr[31:2], 2'b00};
  assign head_match   = (cpu_addr[31:2] == head_addr[31:2]);
  assign hit          = cpu_req && stream_ok && head_match && (count != '0);
  assign pending      = cpu_req && stream_ok && head_match && (count == '0) && inflight;
  assign miss         = cpu_req && !hit && !pending;
  assign take_miss    = miss && !flush;
  assign pop          = hit && !flush;
  assign mem_done     = (state == REQ) && mem_valid;
  assign push         = mem_done && !discard && !flush && !miss;

  // Issue decisions look at the post-update stream so a miss reaches memory on the next cycle.
  always_comb begin
    stream_ok_nx = stream_ok;
    if (flush) begin
      stream_ok_nx = 1'b0;
    end else if (take_miss) begin
      stream_ok_nx = 1'b1;
    end else if (pop && !PREFETCH) begin
      stream_ok_nx = 1'b0;
    end
  end

  always_comb begin
    count_nx = count;
    if (flush || take_miss) begin
      count_nx = '0;
    end else if (push && !pop) begin
      count_nx = count + CW'(1);
    end else if (pop && !push) begin
      count_nx = count - CW'(1);
    end
  end

  assign fetch_addr_base = take_miss ? aligned_addr : fetch_addr;
  assign issue = (state == IDLE) && stream_ok_nx && (count_nx < CW'(QD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stream_ok  <= 1'b0;
      inflight   <= 1'b0;
      discard    <= 1'b0;
      head_addr  <= '0;
      fetch_addr <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cpu_valid  <= 1'b0;
      cpu_instr  <= '0;
      mem_enable <= 1'b0;
      mem_addr   <= '0;
    end else begin
      stream_ok <= stream_ok_nx;
      count     <= count_nx;
      cpu_valid <= pop;

      if (pop) begin
        cpu_instr <= queue[rd_ptr];
      end

      if (flush || take_miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          queue[wr_ptr] <= mem_result;
          wr_ptr        <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
      end

      if (take_miss) begin
        head_addr <= aligned_addr;
      end else if (pop) begin
        head_addr <= head_addr + 32'd4;
      end

      // A word already returning this cycle is dropped directly, so it needs no discard mark.
      if (flush || take_miss) begin
        discard <= inflight && !mem_done;
      end else if (mem_done) begin
        discard <= 1'b0;
      end

      fetch_addr <= issue ? fetch_addr_base + 32'd4 : fetch_addr_base;

      case (state)
        IDLE: begin
          if (issue) begin
            state      <= REQ;
            mem_enable <= 1'b1;
            mem_addr   <= fetch_addr_base[24:0];
            inflight   <= 1'b1;
          end
        end
        REQ: begin
          if (mem_valid) begin
            state      <= IDLE;
            mem_enable <= 1'b0;
            inflight   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mem_enable <= 1'b0;
          inflight   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction prefetch buffer between the CPU core's fetch stage and the instruction port of `memoryController`. The core's fetch request is served from a small FIFO of sequentially prefetched words. The buffer keeps the SDRAM instruction port busy fetching ahead while the core executes. A fetch to a non-sequential address (jump, taken branch) flushes the queue and restarts the stream at the new address.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_enable`  in  1  core fetch request; held high until `cpu_valid`.
- `cpu_addr`  in  32  fetch address (pc); bits [1:0] ignored.
- `cpu_valid`  out  1  one-cycle pulse; `cpu_instr` valid.
- `cpu_instr`  out  32  fetched instruction word.
- `flush`  in  1  invalidate queue (fence.i / code store).
- `mem_enable`  out  1  request to `memoryController` instr port.
- `mem_addr`  out  25  word byte-address to controller.
- `mem_valid`  in  1  controller read-done pulse.
- `mem_result`  in  32  controller read data.

## Operation
- State: `stream_ok`, `head_addr[31:0]` (address of oldest entry), `count` (0..DEPTH), `fetch_addr[31:0]` (next address to request), `inflight`, `discard`.
- Memory FSM, states IDLE and REQ:
  - IDLE -> REQ when `stream_ok` and `count + inflight < DEPTH`. Latch `mem_addr <= fetch_addr[24:0]`, assert `mem_enable`, set `inflight`, `fetch_addr += 4`.
  - REQ: hold `mem_enable` and `mem_addr` stable until `mem_valid`. On `mem_valid`: push `mem_result` unless `discard`, clear `inflight` and `discard`, drop `mem_enable`, return to IDLE.
  - `mem_enable` stays low for at least one cycle between requests.
- Core side, evaluated only when `cpu_enable` is high and `cpu_valid` is low:
  - **Hit**: `stream_ok`, `cpu_addr[31:2] == head_addr[31:2]` and `count > 0`. Pop the head, `head_addr += 4`, and drive `cpu_valid`/`cpu_instr` next cycle.
  - **Pending**: address matches the head, `count == 0`, and a request is in flight. Wait; no change.
  - **Miss**: anything else. Set `count <= 0`, `head_addr <= fetch_addr <= {cpu_addr[31:2],2'b00}`, `stream_ok <= 1`. If a request is in flight, set `discard`.
- `cpu_enable` is ignored in the cycle `cpu_valid` is high. The core's enable is registered and lags one cycle, so acting on it would cause a false miss.
- `flush`: `count <= 0`, `stream_ok <= 0`, `discard <= inflight`. No new request issues until the next miss reloads the stream.
- Priority when events coincide:
  - `flush` > miss > hit.
  - A flush arriving with a hit suppresses `cpu_valid`.
  - `mem_valid` arriving together with a miss or flush: the returned word is discarded.
  - A push and a pop in the same cycle leave `count` unchanged.
- Address arithmetic is modulo 2^32. `mem_addr` is the low 25 bits, so prefetch past 0x1FFFFFC wraps to 0x0000000.

## Timing
- Reset: `cpu_valid=0`, `cpu_instr=0`, `mem_enable=0`, `mem_addr=0`, `count=0`, `stream_ok=0`, `inflight=0`, `discard=0`, FSM=IDLE.
- `rst` asserted mid-request: `mem_enable` drops next edge. A `mem_valid` arriving after reset is ignored.
- Hit latency: `cpu_valid` in cycle T+1, where T is the first cycle `cpu_enable` is high with a hit.
- Miss penalty, controller idle: `mem_enable` at T+1; with `mem_valid` at T+1+L, the word is pushed at T+2+L and `cpu_valid` is high at T+3+L.
- Miss while a request is in flight: the new request is issued only after the outstanding `mem_valid`.
- Queue full (`count + inflight == DEPTH`): no request is issued; issuing resumes the cycle after a pop.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - Speculative sequential prefetch as above, DEPTH entries.
- Undefined:
  - No fetch-ahead; effective depth 1.
  - A request is issued only for the current `cpu_addr` on a miss. After the pop, `stream_ok` clears, so every fetch is a miss.
  - Core-visible latency is L+3 per instruction.

## Test plan
- Reset, then `cpu_enable` with `cpu_addr=0x0`, controller latency L=5 -> `mem_addr=0x0` at cycle 1, `cpu_valid` with word[0] at cycle 8. Prefetch of 0x4, 0x8 and 0xC follows.
- Sequential fetches 0x0..0x1C, core spending 4 cycles per instruction, L=2 -> every fetch after the first returns `cpu_valid` one cycle after `cpu_enable`.
- Jump to 0x100 while the request for 0x10 is in flight -> the 0x10 word is discarded, the next `mem_addr` is 0x100, and `cpu_instr` equals mem[0x100].
- Fill to DEPTH=4 with no core requests -> exactly 4 requests, `mem_enable` stays low. One pop -> one new request.
- `flush` asserted together with a hitting `cpu_enable` -> no `cpu_valid`. Next `cpu_enable` at the same address -> miss, refetched from memory.
- Stream at `fetch_addr=0x01FFFFFC` -> next `mem_addr=0x0000000`. Without `FETCH_PREFETCH_EN`: exactly one request per fetch, none issued ahead.
